// File: rtl/console_apb_writer.sv
// console_apb_writer
//   Upstream feeder for an APB-attached console sink. Bytes arrive on a
//   valid/ready interface, are buffered in a small FIFO and drained as one
//   APB write per byte (SETUP then ACCESS, honouring pready).
//
// Ports
//   clk_i, rst_ni          clock (rising edge), async active-low reset
//   byte_valid_i, byte_i   producer byte stream
//   byte_ready_o           FIFO not full (registered state only)
//   psel_o, penable_o,     APB requester outputs, all registered;
//   pwrite_o, paddr_o,     pwrite follows psel, paddr is CONSOLE_ADDR,
//   pwdata_o               pwdata is {24'h0, byte}
//   pready_i               APB completer ready
//   level_o                FIFO occupancy
//   sent_cnt_o             completed writes, wraps at 2^32
//   err_o, clr_err_i       sticky timeout-abort flag and its clear
module console_apb_writer #(
    parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          TIMEOUT      = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          byte_valid_i,
    input  logic [7:0]                    byte_i,
    output logic                          byte_ready_o,
    output logic                          psel_o,
    output logic                          penable_o,
    output logic                          pwrite_o,
    output logic [31:0]                   paddr_o,
    output logic [31:0]                   pwdata_o,
    input  logic                          pready_i,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic [31:0]                   sent_cnt_o,
    output logic                          err_o,
    input  logic                          clr_err_i
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    // Wait counter only has to reach TIMEOUT-1.
    localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t          state, state_d;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [AW:0]     count;
    logic [WW-1:0]   wait_q, wait_d;
    logic            full, push, pop, sent_inc, err_set;
    logic            psel_d, penable_d;
    logic [31:0]     paddr_d, pwdata_d;

    assign full         = (count == LW'(FIFO_DEPTH));
    assign byte_ready_o = !full;
    // A pop in the same cycle never frees a slot for a push while full.
    assign push         = byte_valid_i && !full;
    assign level_o      = count;
    assign rd_ptr_nxt   = rd_ptr + AW'(1);
    assign pwrite_o     = psel_o;

    // Byte storage carries no reset; occupancy is tracked by count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= byte_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            sent_cnt_o <= '0;
            err_o      <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr_nxt;
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: ;
            endcase
            if (sent_inc) sent_cnt_o <= sent_cnt_o + 32'd1;
            if (err_set)        err_o <= 1'b1;
            else if (clr_err_i) err_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            wait_q    <= '0;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            paddr_o   <= '0;
            pwdata_o  <= '0;
        end else begin
            state     <= state_d;
            wait_q    <= wait_d;
            psel_o    <= psel_d;
            penable_o <= penable_d;
            paddr_o   <= paddr_d;
            pwdata_o  <= pwdata_d;
        end
    end

    always_comb begin
        state_d   = state;
        wait_d    = wait_q;
        psel_d    = psel_o;
        penable_d = penable_o;
        paddr_d   = paddr_o;
        pwdata_d  = pwdata_o;
        pop       = 1'b0;
        sent_inc  = 1'b0;
        err_set   = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_d   = SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    paddr_d   = CONSOLE_ADDR;
                    pwdata_d  = {24'h0, mem[rd_ptr]};
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                wait_d    = '0;
            end
            ACCESS: begin
                if (pready_i) begin
                    pop      = 1'b1;
                    sent_inc = 1'b1;
                    if (count > LW'(1)) begin
                        // Next byte is already buffered: chain straight into SETUP.
                        state_d   = SETUP;
                        penable_d = 1'b0;
                        pwdata_d  = {24'h0, mem[rd_ptr_nxt]};
                    end else begin
                        state_d   = IDLE;
                        psel_d    = 1'b0;
                        penable_d = 1'b0;
                        paddr_d   = '0;
                        pwdata_d  = '0;
                    end
                end else if (TIMEOUT != 0 && wait_q == WAIT_LAST) begin
                    // Completer stuck: drop the byte so the stream keeps moving.
                    pop       = 1'b1;
                    err_set   = 1'b1;
                    state_d   = IDLE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    paddr_d   = '0;
                    pwdata_d  = '0;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
